// File: rtl/nmi_sched.sv
// NMI request scheduler: latches per-source requests, issues a two-cycle set_nmi
// pulse to the NMI generator, and retries or drops the request on INT-count timeout.
module nmi_sched #(
    parameter int NSRC      = 4,
    parameter int TMO_INTS  = 3,
    parameter int MAX_RETRY = 2
) (
    input  logic            fclk,
    input  logic            rst,
    input  logic [NSRC-1:0] req,
    input  logic [NSRC-1:0] mask,
    input  logic            int_start,
    input  logic            in_nmi,
    input  logic            err_clr,
    output logic            set_nmi,
    output logic            busy,
    output logic [1:0]      cur_src,
    output logic [NSRC-1:0] pend,
    output logic            err
);

    localparam logic [1:0] TMO_L = 2'(TMO_INTS);
    localparam logic [1:0] MAX_L = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_WAIT     = 3'd2,
        ST_SERVICE  = 3'd3,
        ST_COOLDOWN = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] req_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic            set_nmi_q, set_nmi_d;
    logic            busy_q, busy_d;
    logic [1:0]      cur_src_q, cur_src_d;
    logic            err_q, err_d;
    logic [1:0]      retry_q, retry_d;
    logic [1:0]      int_cnt_q, int_cnt_d;
    logic            hold_q, hold_d;

    logic [NSRC-1:0] set_s;
    logic [NSRC-1:0] clr_s;
    logic [1:0]      grant_idx_s;
    logic [1:0]      int_cnt_inc_s;
    logic            drop_s;

    // Next-state, grant selection and output computation
    always_comb begin
        set_s         = req & ~req_q & mask;
        grant_idx_s   = 2'd0;
        // Descending scan so the lowest set index is the one left standing
        for (int i = NSRC - 1; i >= 0; i--) begin
            grant_idx_s = pend_q[i] ? 2'(i) : grant_idx_s;
        end
        int_cnt_inc_s = (int_cnt_q == 2'd3) ? 2'd3 : int_cnt_q + 2'd1;

        state_d   = state_q;
        clr_s     = '0;
        set_nmi_d = 1'b0;
        cur_src_d = cur_src_q;
        retry_d   = retry_q;
        int_cnt_d = int_cnt_q;
        hold_d    = 1'b0;
        drop_s    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((pend_q != '0) && !in_nmi) begin
                    clr_s     = {{(NSRC-1){1'b0}}, 1'b1} << grant_idx_s;
                    cur_src_d = grant_idx_s;
                    retry_d   = 2'd0;
                    set_nmi_d = 1'b1;
                    state_d   = ST_ISSUE;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (!hold_q) begin
                    set_nmi_d = 1'b1;
                    hold_d    = 1'b1;
                end else begin
                    int_cnt_d = 2'd0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // in_nmi is tested first so it beats a same-cycle timeout
                if (in_nmi) begin
                    state_d = ST_SERVICE;
                end else if (int_start) begin
                    if (int_cnt_inc_s == TMO_L) begin
                        if (retry_q < MAX_L) begin
                            retry_d   = retry_q + 2'd1;
                            set_nmi_d = 1'b1;
                            state_d   = ST_ISSUE;
                        end else begin
                            drop_s    = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end else begin
                        int_cnt_d = int_cnt_inc_s;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SERVICE: begin
                if (!in_nmi) begin
                    state_d = ST_COOLDOWN;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            ST_COOLDOWN: begin
                if (int_start) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_COOLDOWN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pend_d = (pend_q & ~clr_s) | set_s;
        err_d  = drop_s ? 1'b1 : (err_clr ? 1'b0 : err_q);
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; req_q resets high so held requests are not edges
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            req_q     <= {NSRC{1'b1}};
            pend_q    <= '0;
            set_nmi_q <= 1'b0;
            busy_q    <= 1'b0;
            cur_src_q <= 2'd0;
            err_q     <= 1'b0;
            retry_q   <= 2'd0;
            int_cnt_q <= 2'd0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req;
            pend_q    <= pend_d;
            set_nmi_q <= set_nmi_d;
            busy_q    <= busy_d;
            cur_src_q <= cur_src_d;
            err_q     <= err_d;
            retry_q   <= retry_d;
            int_cnt_q <= int_cnt_d;
            hold_q    <= hold_d;
        end
    end

    assign set_nmi = set_nmi_q;
    assign busy    = busy_q;
    assign cur_src = cur_src_q;
    assign pend    = pend_q;
    assign err     = err_q;

endmodule

// File: tb/tb_nmi_sched.sv
// Directed self-checking bench for nmi_sched; expected output vectors are hand-derived.
module tb_nmi_sched;

    logic       fclk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] mask;
    logic       int_start;
    logic       in_nmi;
    logic       err_clr;
    logic       set_nmi;
    logic       busy;
    logic [1:0] cur_src;
    logic [3:0] pend;
    logic       err;

    int n_assert = 0;
    int n_fail   = 0;

    nmi_sched #(.NSRC(4), .TMO_INTS(3), .MAX_RETRY(2)) dut (
        .fclk      (fclk),
        .rst       (rst),
        .req       (req),
        .mask      (mask),
        .int_start (int_start),
        .in_nmi    (in_nmi),
        .err_clr   (err_clr),
        .set_nmi   (set_nmi),
        .busy      (busy),
        .cur_src   (cur_src),
        .pend      (pend),
        .err       (err)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    // Advance one clock and settle 1 time unit past the edge
    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    task automatic pulse_int();
        int_start = 1'b1;
        tick();
        int_start = 1'b0;
    endtask

    // Compare {set_nmi, busy, cur_src, pend, err} against expected
    task automatic expect_out(input string tag, input logic s, input logic b,
                              input logic [1:0] c, input logic [3:0] p, input logic e);
        logic [8:0] obs;
        logic [8:0] exp_v;
        obs   = {set_nmi, busy, cur_src, pend, err};
        exp_v = {s, b, c, p, e};
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $display("FAIL %s: observed set/busy/src/pend/err=%b expected %b", tag, obs, exp_v);
            $error("check %s", tag);
        end
    endtask

    initial begin
        rst = 1'b1; req = 4'h0; mask = 4'hF;
        int_start = 1'b0; in_nmi = 1'b0; err_clr = 1'b0;
        tick(); tick();
        expect_out("reset", 1'b0, 1'b0, 2'd0, 4'h0, 1'b0);
        rst = 1'b0;
        tick();

        // Grant and service of source 2
        req = 4'b0100; tick();
        expect_out("A_latch", 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0);
        tick();
        expect_out("A_grant", 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0);
        tick();
        expect_out("A_issue2", 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0);
        tick();
        expect_out("A_wait", 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0);
        in_nmi = 1'b1; tick();
        expect_out("A_service", 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0);
        in_nmi = 1'b0; tick(); tick();
        expect_out("A_cooldown", 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0);
        pulse_int();
        expect_out("A_done", 1'b0, 1'b0, 2'd2, 4'b0000, 1'b0);
        req = 4'b0000; tick();

        // Priority: sources 3 and 1 together
        req = 4'b1010; tick();
        expect_out("B_latch", 1'b0, 1'b0, 2'd2, 4'b1010, 1'b0);
        tick();
        expect_out("B_grant1", 1'b1, 1'b1, 2'd1, 4'b1000, 1'b0);
        tick(); tick();
        expect_out("B_wait1", 1'b0, 1'b1, 2'd1, 4'b1000, 1'b0);
        in_nmi = 1'b1; tick();
        in_nmi = 1'b0; tick();
        pulse_int();
        expect_out("B_idle", 1'b0, 1'b0, 2'd1, 4'b1000, 1'b0);
        tick();
        expect_out("B_grant3", 1'b1, 1'b1, 2'd3, 4'b0000, 1'b0);
        tick(); tick();
        in_nmi = 1'b1; tick();
        in_nmi = 1'b0; tick();
        pulse_int();
        expect_out("B_done", 1'b0, 1'b0, 2'd3, 4'b0000, 1'b0);
        req = 4'b0000; tick();

        // Timeout, two retries, then drop
        req = 4'b0001; tick();
        expect_out("C_latch", 1'b0, 1'b0, 2'd3, 4'b0001, 1'b0);
        tick();
        expect_out("C_grant", 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0);
        tick(); tick();
        expect_out("C_wait0", 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0);
        pulse_int(); pulse_int();
        expect_out("C_two_ints", 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0);
        pulse_int();
        expect_out("C_retry1", 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0);
        tick();
        expect_out("C_retry1_b", 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0);
        tick();
        pulse_int(); pulse_int();
        expect_out("C_wait1", 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0);
        pulse_int();
        expect_out("C_retry2", 1'b1, 1'b1, 2'd0, 4'b0000, 1'b0);
        tick(); tick();
        pulse_int(); pulse_int();
        expect_out("C_wait2", 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0);
        pulse_int();
        expect_out("C_drop", 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        expect_out("C_errclr", 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
        req = 4'b0000; tick();

        // in_nmi on the third int_start wins over the timeout
        req = 4'b0010; tick(); tick(); tick(); tick();
        pulse_int(); pulse_int();
        in_nmi = 1'b1; int_start = 1'b1; tick(); int_start = 1'b0;
        expect_out("D_collide", 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0);
        tick();
        expect_out("D_no_reissue", 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0);
        in_nmi = 1'b0; tick();
        pulse_int();
        expect_out("D_done", 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0);
        req = 4'b0000; tick();

        // err_clr on the drop cycle: set wins
        req = 4'b0100; tick(); tick(); tick(); tick();
        pulse_int(); pulse_int(); pulse_int();
        tick(); tick();
        pulse_int(); pulse_int(); pulse_int();
        tick(); tick();
        pulse_int(); pulse_int();
        int_start = 1'b1; err_clr = 1'b1; tick();
        int_start = 1'b0; err_clr = 1'b0;
        expect_out("D_drop_errclr", 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1);
        req = 4'b0000; tick();

        // Masked source and externally caused NMI
        mask = 4'b1110; req = 4'b0001; tick();
        expect_out("E_masked", 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1);
        tick();
        expect_out("E_masked_idle", 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1);
        mask = 4'hF; req = 4'b0000; in_nmi = 1'b1; tick();
        req = 4'b0100; tick();
        expect_out("E_ext_latch", 1'b0, 1'b0, 2'd2, 4'b0100, 1'b1);
        tick(); tick();
        expect_out("E_ext_hold", 1'b0, 1'b0, 2'd2, 4'b0100, 1'b1);
        in_nmi = 1'b0; tick();
        expect_out("E_ext_grant", 1'b1, 1'b1, 2'd2, 4'b0000, 1'b1);
        tick(); tick();
        in_nmi = 1'b1; tick();
        in_nmi = 1'b0; tick();
        pulse_int();
        expect_out("E_done", 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1);
        req = 4'b0000; tick();

        // Asynchronous reset during the first set_nmi cycle
        req = 4'b0001; tick(); tick();
        expect_out("F_issue", 1'b1, 1'b1, 2'd0, 4'b0000, 1'b1);
        #2 rst = 1'b1;
        #1;
        expect_out("F_async_rst", 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
        req = 4'hF; tick();
        expect_out("F_in_rst", 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
        rst = 1'b0; tick(); tick();
        expect_out("F_held_req", 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0);
        req = 4'b0000; tick();
        req = 4'b0001; tick();
        expect_out("F_after_rst", 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nmi_sched.md
NMI_SCHED -- requirements
Module: nmi_sched

Interface
REQ-001 Parameter NSRC, default 4: number of NMI requesters; the design is fixed at 4 and all widths below assume it.
REQ-002 Parameter TMO_INTS, default 3: int_start strobes allowed between the end of a set_nmi pulse and in_nmi rising.
REQ-003 Parameter MAX_RETRY, default 2: number of re-issues allowed after a timeout before the request is dropped.
REQ-004 Port fclk, input, 1 bit: sole clock; all state is updated on its posedge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port req[3:0], input, 4 bits: per-source NMI request; each rising edge is one request; index 0 has highest priority.
REQ-007 Port mask[3:0], input, 4 bits: per-source enable; a 0 bit blocks latching of new requests from that source.
REQ-008 Port int_start, input, 1 bit: one-fclk strobe marking the start of each frame INT.
REQ-009 Port in_nmi, input, 1 bit: NMI-service flag from the NMI generator.
REQ-010 Port err_clr, input, 1 bit: synchronous clear of err.
REQ-011 Port set_nmi, output, 1 bit: request pulse to the NMI generator, which acts on its falling edge.
REQ-012 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 Port cur_src[1:0], output, 2 bits: encoded index of the last granted source.
REQ-014 Port pend[3:0], output, 4 bits: latched pending requests.
REQ-015 Port err, output, 1 bit: sticky flag, set when a request is dropped.

Function
REQ-016 Edge detect: req is registered each cycle into req_r; a rise is req[i]=1 while req_r[i]=0.
REQ-017 Latching: a rise on a source with mask[i]=1 sets pend[i]; mask has no effect on bits already latched.
REQ-018 Set/clear collision: if pend[i] is set and cleared in the same cycle, set wins.
REQ-019 State machine states: IDLE, ISSUE, WAIT, SERVICE, COOLDOWN.
REQ-020 IDLE grant: when pend!=0 and in_nmi=0, the scheduler selects the lowest set index, loads cur_src, clears that pend bit, zeroes the retry count and enters ISSUE on the next cycle.
REQ-021 IDLE hold: while in_nmi=1 (externally caused NMI), no grant is made.
REQ-022 ISSUE: set_nmi is high for exactly 2 fclk cycles, starting on the cycle after the grant; it then falls, the int_start count is zeroed and the state moves to WAIT.
REQ-023 WAIT, success: in_nmi=1 moves the state to SERVICE.
REQ-024 WAIT, counting: each int_start increments a 2-bit saturating counter.
REQ-025 WAIT, timeout: when the counter reaches TMO_INTS with in_nmi=0, the scheduler re-enters ISSUE if retries<MAX_RETRY and increments retries.
REQ-026 WAIT, drop: on timeout with retries=MAX_RETRY, err is set and the state returns to IDLE; the dropped request is not re-pended.
REQ-027 WAIT, collision: if in_nmi=1 and the timeout occur in the same cycle, in_nmi wins and the state goes to SERVICE.
REQ-028 SERVICE: the scheduler stays until in_nmi=0, then enters COOLDOWN.
REQ-029 COOLDOWN: the scheduler waits for the next int_start, then returns to IDLE; no grant is made in the same cycle as that int_start.
REQ-030 New requests are latched in every state; they do not pre-empt the request being served.
REQ-031 err: set on drop, cleared by err_clr; if both happen in the same cycle, set wins.
REQ-032 All outputs are registered; set_nmi is glitch-free.

Reset
REQ-033 While rst=1, the outputs shall be: state=IDLE, set_nmi=0, busy=0, cur_src=0, pend=0, err=0; retries and the int_start count are 0.
REQ-034 req_r resets to 4'b1111, so a req held high through reset release is not counted as a request.
REQ-035 Reset asserted mid-operation drives set_nmi low immediately (asynchronously) and discards all pending and in-service requests.

Verification
REQ-036 Grant and service: req[2] rises with mask=4'hF -> set_nmi high for 2 cycles, cur_src=2, pend=0; in_nmi=1 then 0 -> COOLDOWN; next int_start -> busy=0.
REQ-037 Priority: req[3] and req[1] rise in the same cycle -> cur_src=1, pend=4'b1000; after source 1 completes, source 3 is granted with cur_src=3.
REQ-038 Timeout and drop: in_nmi is held 0 -> 3 set_nmi pulses in total, each followed by 3 int_start strobes -> err=1, busy=0, pend unchanged.
REQ-039 Collisions: in_nmi rises on the 3rd int_start in WAIT -> state SERVICE with no re-issue; err_clr pulsed on the drop cycle -> err=1.
REQ-040 Masking and external NMI: req[0] rises with mask[0]=0 -> pend[0]=0; in_nmi=1 in IDLE with pend=4'b0100 -> no set_nmi until in_nmi=0.
REQ-041 Reset: rst asserted during the first set_nmi cycle -> set_nmi=0 within the same cycle, all outputs at reset values; req held at 4'hF across reset release -> pend stays 0.
